// File: rtl/ctrl_pipeline.sv
// Control-path pipeline: carries decoded ID control fields through EX, MEM and WB,
// inserts bubbles on hazards, drains and halts on a halt instruction, counts retirements.
module ctrl_pipeline #(
  parameter int CTRL_WIDTH = 15
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic                  i_id_valid,
  input  logic [CTRL_WIDTH-1:0] i_ctrl_regs,
  input  logic                  i_stall,
  input  logic                  i_flush,
  input  logic                  i_halt,
  output logic                  o_ex_reg_write,
  output logic [1:0]            o_ex_reg_dst,
  output logic [1:0]            o_ex_mem_to_reg,
  output logic                  o_ex_mem_write,
  output logic                  o_ex_alu_src_a,
  output logic [1:0]            o_ex_alu_src_b,
  output logic [2:0]            o_ex_alu_op,
  output logic                  o_mem_reg_write,
  output logic [1:0]            o_mem_mem_to_reg,
  output logic                  o_mem_mem_write,
  output logic                  o_wb_reg_write,
  output logic [1:0]            o_wb_mem_to_reg,
  output logic                  o_halted,
  output logic [31:0]           o_retired_count
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state;
  state_t      state_d;
  logic        ex_valid;
  logic        mem_valid;
  logic        wb_valid;
  logic        ex_bubble;
  logic        ex_load;
  logic        halted_d;
  logic [31:0] retired_count;

  // next_pc_src / jmp_ctrl are resolved in ID and deliberately not carried forward
  logic unused_id_bits;
  logic unused_wb;
  assign unused_id_bits = ^i_ctrl_regs[CTRL_WIDTH-1:12];
  assign unused_wb      = wb_valid;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state    <= RUN;
      o_halted <= 1'b0;
    end else if (i_enable) begin
      state    <= state_d;
      o_halted <= halted_d;
    end
  end

  always_comb begin
    state_d = state;
    if (i_enable) begin
      case (state)
        RUN:     if (i_halt) state_d = DRAIN;
        DRAIN:   if (!ex_valid && !mem_valid) state_d = HALTED;
        HALTED:  state_d = HALTED;
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    ex_bubble = i_stall || i_flush || i_halt || (state != RUN);
    ex_load   = !ex_bubble && i_id_valid;
    halted_d  = (state_d == HALTED);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      ex_valid         <= 1'b0;
      o_ex_reg_write   <= 1'b0;
      o_ex_reg_dst     <= '0;
      o_ex_mem_to_reg  <= '0;
      o_ex_mem_write   <= 1'b0;
      o_ex_alu_src_a   <= 1'b0;
      o_ex_alu_src_b   <= '0;
      o_ex_alu_op      <= '0;
      mem_valid        <= 1'b0;
      o_mem_reg_write  <= 1'b0;
      o_mem_mem_to_reg <= '0;
      o_mem_mem_write  <= 1'b0;
      wb_valid         <= 1'b0;
      o_wb_reg_write   <= 1'b0;
      o_wb_mem_to_reg  <= '0;
      retired_count    <= '0;
    end else if (i_enable) begin
      mem_valid        <= ex_valid;
      o_mem_reg_write  <= o_ex_reg_write;
      o_mem_mem_to_reg <= o_ex_mem_to_reg;
      o_mem_mem_write  <= o_ex_mem_write;
      wb_valid         <= mem_valid;
      o_wb_reg_write   <= o_mem_reg_write;
      o_wb_mem_to_reg  <= o_mem_mem_to_reg;
      if (ex_load) begin
        ex_valid        <= 1'b1;
        o_ex_reg_write  <= i_ctrl_regs[11];
        o_ex_reg_dst    <= i_ctrl_regs[10:9];
        o_ex_mem_to_reg <= i_ctrl_regs[8:7];
        o_ex_mem_write  <= i_ctrl_regs[6];
        o_ex_alu_src_a  <= i_ctrl_regs[5];
        o_ex_alu_src_b  <= i_ctrl_regs[4:3];
        o_ex_alu_op     <= i_ctrl_regs[2:0];
      end else begin
        ex_valid        <= 1'b0;
        o_ex_reg_write  <= 1'b0;
        o_ex_reg_dst    <= '0;
        o_ex_mem_to_reg <= '0;
        o_ex_mem_write  <= 1'b0;
        o_ex_alu_src_a  <= 1'b0;
        o_ex_alu_src_b  <= '0;
        o_ex_alu_op     <= '0;
      end
      if (mem_valid) retired_count <= retired_count + 32'd1;
    end
  end

  assign o_retired_count = retired_count;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Scoreboard bench for ctrl_pipeline: stimulus pushes predictions from a stage-list model,
// a negedge monitor pops and compares; async reset and counter wrap are checked directly.
module tb_ctrl_pipeline;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_enable = 1'b0;
  logic        i_id_valid = 1'b0;
  logic [14:0] i_ctrl_regs = '0;
  logic        i_stall = 1'b0;
  logic        i_flush = 1'b0;
  logic        i_halt = 1'b0;
  logic        o_ex_reg_write, o_ex_mem_write, o_ex_alu_src_a;
  logic [1:0]  o_ex_reg_dst, o_ex_mem_to_reg, o_ex_alu_src_b;
  logic [2:0]  o_ex_alu_op;
  logic        o_mem_reg_write, o_mem_mem_write, o_wb_reg_write, o_halted;
  logic [1:0]  o_mem_mem_to_reg, o_wb_mem_to_reg;
  logic [31:0] o_retired_count;

  always #5 clk = ~clk;

  ctrl_pipeline #(.CTRL_WIDTH(15)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_enable(i_enable), .i_id_valid(i_id_valid),
    .i_ctrl_regs(i_ctrl_regs), .i_stall(i_stall), .i_flush(i_flush), .i_halt(i_halt),
    .o_ex_reg_write(o_ex_reg_write), .o_ex_reg_dst(o_ex_reg_dst),
    .o_ex_mem_to_reg(o_ex_mem_to_reg), .o_ex_mem_write(o_ex_mem_write),
    .o_ex_alu_src_a(o_ex_alu_src_a), .o_ex_alu_src_b(o_ex_alu_src_b),
    .o_ex_alu_op(o_ex_alu_op), .o_mem_reg_write(o_mem_reg_write),
    .o_mem_mem_to_reg(o_mem_mem_to_reg), .o_mem_mem_write(o_mem_mem_write),
    .o_wb_reg_write(o_wb_reg_write), .o_wb_mem_to_reg(o_wb_mem_to_reg),
    .o_halted(o_halted), .o_retired_count(o_retired_count)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct packed {
    logic [11:0] ex;
    logic [3:0]  mem;
    logic [2:0]  wb;
    logic        halted;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  typedef enum int {M_RUN, M_DRAIN, M_HALTED} mode_t;

  // Model: three slots holding the instruction word (zero for a bubble) and a valid flag
  logic [11:0] m_word[3];
  bit          m_vld[3];
  mode_t       m_mode;
  logic [31:0] m_cnt;

  localparam logic [14:0] W_ADDI = 15'b000_1_00_00_0_0_01_000;
  localparam logic [14:0] W_SW   = 15'b000_0_00_00_1_0_01_000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic exp_t snapshot();
    exp_t e;
    e.ex     = m_word[0];
    e.mem    = {m_word[1][11], m_word[1][8:7], m_word[1][6]};
    e.wb     = {m_word[2][11], m_word[2][8:7]};
    e.halted = (m_mode == M_HALTED);
    e.cnt    = m_cnt;
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_word[i] = '0;
      m_vld[i]  = 1'b0;
    end
    m_mode = M_RUN;
    m_cnt  = '0;
  endtask

  task automatic model_edge();
    bit ex_was, mem_was;
    if (!i_enable) return;
    ex_was  = m_vld[0];
    mem_was = m_vld[1];
    if (mem_was) m_cnt = m_cnt + 32'd1;
    m_word[2] = m_word[1]; m_vld[2] = m_vld[1];
    m_word[1] = m_word[0]; m_vld[1] = m_vld[0];
    if (i_stall || i_flush || i_halt || m_mode != M_RUN || !i_id_valid) begin
      m_word[0] = '0;
      m_vld[0]  = 1'b0;
    end else begin
      m_word[0] = i_ctrl_regs[11:0];
      m_vld[0]  = 1'b1;
    end
    if (m_mode == M_RUN && i_halt) m_mode = M_DRAIN;
    else if (m_mode == M_DRAIN && !ex_was && !mem_was) m_mode = M_HALTED;
  endtask

  task automatic step(input bit en, input bit idv, input logic [14:0] ctrl,
                      input bit stall, input bit flush, input bit halt);
    @(negedge clk);
    #1;
    i_enable = en; i_id_valid = idv; i_ctrl_regs = ctrl;
    i_stall = stall; i_flush = flush; i_halt = halt;
    model_edge();
    exp_q.push_back(snapshot());
  endtask

  task automatic rand_step(input int halt_pct);
    step($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7, 15'($urandom),
         $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 10,
         $urandom_range(0, 99) < halt_pct);
  endtask

  // Park the inputs disabled and let the monitor consume everything outstanding
  task automatic drain_q();
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    if (exp_q.size() != 0) chk("queue_empty", exp_q.size(), 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ex"}, {o_ex_reg_write, o_ex_reg_dst, o_ex_mem_to_reg, o_ex_mem_write,
                       o_ex_alu_src_a, o_ex_alu_src_b, o_ex_alu_op}, 0);
    chk({tag, "_mem"}, {o_mem_reg_write, o_mem_mem_to_reg, o_mem_mem_write}, 0);
    chk({tag, "_wb"}, {o_wb_reg_write, o_wb_mem_to_reg}, 0);
    chk({tag, "_halted"}, o_halted, 0);
    chk({tag, "_cnt"}, o_retired_count, 0);
  endtask

  // Asserted between clock edges; outputs must clear before any edge arrives
  task automatic async_reset(input string tag);
    drain_q();
    i_reset = 1'b0;
    #1;
    check_zero(tag);
    model_reset();
    @(posedge clk);
    #2;
    i_reset = 1'b1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("ex_fields", {o_ex_reg_write, o_ex_reg_dst, o_ex_mem_to_reg, o_ex_mem_write,
                        o_ex_alu_src_a, o_ex_alu_src_b, o_ex_alu_op}, e.ex);
      chk("mem_fields", {o_mem_reg_write, o_mem_mem_to_reg, o_mem_mem_write}, e.mem);
      chk("wb_fields", {o_wb_reg_write, o_wb_mem_to_reg}, e.wb);
      chk("halted", o_halted, e.halted);
      chk("retired_count", o_retired_count, e.cnt);
    end
  end

  initial begin
    model_reset();
    #2 i_reset = 1'b0;
    #1 check_zero("por");
    #9 i_reset = 1'b1;

    // Straight line: a single addi flows EX -> MEM -> WB and retires
    step(1, 1, W_ADDI, 0, 0, 0);
    step(1, 0, '0, 0, 0, 0);
    step(1, 0, '0, 0, 0, 0);
    drain_q();
    chk("straight_cnt", o_retired_count, 1);

    // Hazards: stall, then stall+flush together, then the word goes through
    step(1, 1, W_SW, 1, 0, 0);
    step(1, 1, W_SW, 1, 1, 0);
    step(1, 1, W_SW, 0, 0, 0);
    step(1, 1, W_ADDI, 0, 1, 0);
    step(1, 1, W_ADDI, 0, 0, 0);

    // Enable freeze with a full pipe, then resume
    step(1, 1, W_SW, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 15'($urandom), $urandom_range(0, 1), 0, 0);
    step(1, 1, W_ADDI, 0, 0, 0);
    step(1, 0, '0, 0, 0, 0);

    for (int i = 0; i < 300; i++) rand_step(0);

    // Counter wrap: empty the pipe, preload the counter, retire exactly one instruction
    for (int i = 0; i < 3; i++) step(1, 0, '0, 0, 0, 0);
    drain_q();
    dut.retired_count = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    step(1, 1, W_ADDI, 0, 0, 0);
    step(1, 0, '0, 0, 0, 0);
    step(1, 0, '0, 0, 0, 0);
    drain_q();
    chk("wrap_cnt", o_retired_count, 0);

    // Halt with one instruction in EX; later ID traffic must be ignored
    async_reset("rst_a");
    for (int i = 0; i < 7; i++) step(1, 1, W_ADDI, 0, 0, 0);
    step(1, 1, W_ADDI, 0, 0, 1);
    for (int i = 0; i < 6; i++) step(1, 1, W_SW, $urandom_range(0, 1), $urandom_range(0, 1), 1);
    drain_q();
    chk("halted_after_drain", o_halted, 1);
    chk("count_seven", o_retired_count, 7);
    async_reset("rst_halted");

    // Empty-pipe halt, and reset while still draining
    step(1, 0, '0, 0, 0, 1);
    step(1, 0, '0, 0, 0, 0);
    drain_q();
    chk("empty_halt", o_halted, 1);
    async_reset("rst_empty");
    step(1, 1, W_ADDI, 0, 0, 0);
    step(1, 1, W_SW, 0, 0, 1);
    async_reset("rst_drain");
    step(1, 1, W_ADDI, 0, 0, 0);
    step(1, 1, W_SW, 0, 0, 0);
    step(1, 0, '0, 0, 0, 0);

    // Random traffic with occasional halts and resets from DRAIN or HALTED
    for (int i = 0; i < 600; i++) begin
      if (m_mode == M_HALTED && $urandom_range(0, 7) == 0) async_reset("rst_rand_halted");
      else if (m_mode == M_DRAIN && $urandom_range(0, 11) == 0) async_reset("rst_rand_drain");
      else rand_step(3);
    end
    drain_q();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
